// File: rtl/falling_column.sv
// falling_column: one playfield column of the Flippin Bits game.
// A pseudo-random target byte is spawned at the top row and falls one row
// every TICKS_PER_ROW clocks. The player scores by setting the switches to
// the target byte. If the byte times out on the bottom row, the column
// latches game_over until reset.
module falling_column #(
  parameter int unsigned TICKS_PER_ROW = 12500000,
  parameter int unsigned ROWS          = 30,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic [7:0] user_input,
  output logic [4:0] ypos,
  output logic [7:0] letter,
  output logic       correct,
  output logic       game_over
);

  localparam int unsigned       TICK_W    = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_ROW - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0]        LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {
    SPAWN,
    FALL,
    HIT,
    OVER
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [7:0]        lfsr;
  logic [7:0]        in_q;
  logic              lfsr_fb;
  logic              match;
  logic              match_q;
  logic              hit;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign match   = (in_q == letter);
  // Only the rising edge of a match scores, so holding the answer scores once.
  assign hit     = match & ~match_q;

  // Free-running LFSR and one-stage capture of the asynchronous switch byte.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      lfsr <= LFSR_INIT;
      in_q <= 8'h00;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      in_q <= user_input;
    end
  end

  // Column state machine: spawn, fall with row timer, score on hit, latch game over.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state     <= SPAWN;
      ypos      <= 5'd0;
      letter    <= 8'h00;
      correct   <= 1'b0;
      game_over <= 1'b0;
      tick      <= '0;
      match_q   <= 1'b0;
    end else begin
      case (state)
        SPAWN: begin
          letter  <= (lfsr == in_q) ? (lfsr ^ 8'h01) : lfsr;
          ypos    <= 5'd0;
          tick    <= '0;
          match_q <= 1'b0;
          correct <= 1'b0;
          state   <= FALL;
        end
        FALL: begin
          match_q <= match;
          if (tick == TICK_LAST) begin
            tick <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
          if (hit) begin
            correct <= 1'b1;
            state   <= HIT;
          end else if (tick == TICK_LAST) begin
            if (ypos == ROW_LAST) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              ypos <= ypos + 5'd1;
            end
          end
        end
        HIT: begin
          correct <= 1'b0;
          state   <= SPAWN;
        end
        OVER: begin
          correct   <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          state <= SPAWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falling_column.sv
// tb_falling_column: scoreboard bench for falling_column with a short fall
// period and four rows. Stimulus pushes expected column events (spawn, hit,
// game over) into a queue; a monitor pops them whenever the DUT shows one.
module tb_falling_column;

  localparam int unsigned TICKS = 4;
  localparam int unsigned ROWS  = 4;

  localparam logic [1:0] EV_SPAWN = 2'd0;
  localparam logic [1:0] EV_HIT   = 2'd1;
  localparam logic [1:0] EV_OVER  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] letter;
    logic [4:0] ypos;
    logic       correct;
    logic       game_over;
  } event_t;

  logic       clock = 1'b0;
  logic       reset_signal = 1'b0;
  logic       reset_zero = 1'b0;
  logic [7:0] user_input = 8'h00;
  logic [7:0] user_input_zero = 8'h00;
  logic [4:0] ypos;
  logic [7:0] letter;
  logic       correct;
  logic       game_over;
  logic [4:0] ypos_zero;
  logic [7:0] letter_zero;
  logic       correct_zero;
  logic       game_over_zero;

  int check_count = 0;
  int error_count = 0;
  int cyc_e = 0;

  event_t exp_q[$];

  falling_column #(.TICKS_PER_ROW(TICKS), .ROWS(ROWS), .SEED(8'hA5)) dut (
    .clock(clock),
    .reset_signal(reset_signal),
    .user_input(user_input),
    .ypos(ypos),
    .letter(letter),
    .correct(correct),
    .game_over(game_over)
  );

  falling_column #(.TICKS_PER_ROW(TICKS), .ROWS(ROWS), .SEED(8'h00)) dut_zero (
    .clock(clock),
    .reset_signal(reset_zero),
    .user_input(user_input_zero),
    .ypos(ypos_zero),
    .letter(letter_zero),
    .correct(correct_zero),
    .game_over(game_over_zero)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] lfsr_at(input logic [7:0] seed, input int n);
    logic [7:0] x;
    x = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < (n % 255); i++) begin
      x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
    return x;
  endfunction

  function automatic logic [7:0] spawn_letter(input logic [7:0] l, input logic [7:0] held);
    return (l == held) ? (l ^ 8'h01) : l;
  endfunction

  task automatic pushExpect(input logic [1:0] kind, input logic [7:0] l, input logic [4:0] y);
    event_t e;
    e.kind      = kind;
    e.letter    = l;
    e.ypos      = y;
    e.correct   = (kind == EV_HIT);
    e.game_over = (kind == EV_OVER);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic scoreEvent(input logic [1:0] kind);
    event_t seen;
    event_t want;
    seen = {kind, letter, ypos, correct, game_over};
    check_count++;
    if (exp_q.size() == 0) begin
      error_count++;
      $display("[TB] FAIL event_unexpected: got kind=%0d letter=%h ypos=%0d correct=%b game_over=%b, required no event (t=%0t)",
               kind, letter, ypos, correct, game_over, $time);
    end else begin
      want = exp_q.pop_front();
      if (seen !== want) begin
        error_count++;
        $display("[TB] FAIL event_kind%0d: got kind=%0d letter=%h ypos=%0d correct=%b game_over=%b, required kind=%0d letter=%h ypos=%0d correct=%b game_over=%b (t=%0t)",
                 want.kind, seen.kind, seen.letter, seen.ypos, seen.correct, seen.game_over,
                 want.kind, want.letter, want.ypos, want.correct, want.game_over, $time);
      end
    end
  endtask

  task automatic advanceCycles(input int n);
    repeat (n) @(negedge clock);
    cyc_e += n;
  endtask

  task automatic applyStimulus(input logic [7:0] value, input int cycles);
    user_input = value;
    advanceCycles(cycles);
  endtask

  task automatic releaseReset();
    #1 reset_signal = 1'b1;
    cyc_e = 0;
  endtask

  task automatic assertReset();
    #1 reset_signal = 1'b0;
  endtask

  // Monitor: detects column events on the falling edge and scores them.
  initial begin
    int  pend;
    logic prev_correct;
    logic prev_go;
    pend = 1;
    prev_correct = 1'b0;
    prev_go = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_signal) begin
        pend = 1;
        prev_correct = 1'b0;
        prev_go = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) scoreEvent(EV_SPAWN);
        end
        if (correct && !prev_correct) begin
          scoreEvent(EV_HIT);
          pend = 2;
        end
        if (game_over && !prev_go) scoreEvent(EV_OVER);
        prev_correct = correct;
        prev_go = game_over;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    error_count++;
    $display("[TB] FAIL watchdog: got timeout at t=%0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] l2, x, y, z, want, prev_in;
    int spawn_edge;

    // Reset state of both instances.
    repeat (2) @(negedge clock);
    checkOutput("reset_state", {17'b0, game_over, correct, ypos, letter}, 32'h0);
    checkOutput("reset_state_zero", {17'b0, game_over_zero, correct_zero, ypos_zero, letter_zero}, 32'h0);

    // Untouched column: falls row by row and times out on the bottom row.
    pushExpect(EV_SPAWN, 8'hA5, 5'd0);
    pushExpect(EV_OVER, 8'hA5, 5'd3);
    releaseReset();
    for (int i = 0; i < 16; i++) begin
      advanceCycles(1);
      checkOutput("row_step", {27'b0, ypos}, (cyc_e - 1) / 4);
    end
    for (int i = 0; i < 50; i++) begin
      advanceCycles(1);
      checkOutput("over_hold", {17'b0, game_over, correct, ypos, letter}, {17'b0, 1'b1, 1'b0, 5'd3, 8'hA5});
    end

    // Hit at row 1, then respawn.
    assertReset();
    user_input = 8'h00;
    pushExpect(EV_SPAWN, 8'hA5, 5'd0);
    advanceCycles(2);
    releaseReset();
    advanceCycles(5);
    checkOutput("row1_before_hit", {27'b0, ypos}, 32'd1);
    l2 = spawn_letter(lfsr_at(8'hA5, 8), 8'hA5);
    pushExpect(EV_HIT, 8'hA5, 5'd1);
    pushExpect(EV_SPAWN, l2, 5'd0);
    applyStimulus(8'hA5, 5);

    // Held old answer must not score again; then hit and force a spawn collision.
    x = lfsr_at(8'hA5, 13);
    pushExpect(EV_HIT, l2, 5'd0);
    pushExpect(EV_SPAWN, x ^ 8'h01, 5'd0);
    applyStimulus(l2, 2);
    applyStimulus(x, 16);

    // Match edge lands on the same cycle as the bottom-row timeout.
    checkOutput("row3_pre_timeout", {27'b0, ypos}, 32'd3);
    y = x ^ 8'h01;
    z = spawn_letter(lfsr_at(8'hA5, 31), y);
    pushExpect(EV_HIT, y, 5'd3);
    pushExpect(EV_SPAWN, z, 5'd0);
    applyStimulus(y, 3);
    checkOutput("no_game_over_on_hit", {30'b0, game_over, correct}, 32'h0);
    advanceCycles(10);

    // Asynchronous reset in the middle of a fall (row 2, tick 1).
    checkOutput("row2_before_reset", {27'b0, ypos}, 32'd2);
    assertReset();
    #1;
    checkOutput("async_reset", {17'b0, game_over, correct, ypos, letter}, 32'h0);
    user_input = 8'h00;
    pushExpect(EV_SPAWN, 8'hA5, 5'd0);
    pushExpect(EV_OVER, 8'hA5, 5'd3);
    advanceCycles(2);
    releaseReset();
    advanceCycles(3);
    checkOutput("letter_after_reset", {24'b0, letter}, 32'h0000_00A5);

    // Zero seed: 255 consecutive spawns solved as soon as they appear.
    #1 reset_zero = 1'b1;
    cyc_e = 0;
    spawn_edge = 1;
    prev_in = 8'h00;
    for (int k = 0; k < 255; k++) begin
      want = spawn_letter(lfsr_at(8'h00, spawn_edge - 1), prev_in);
      advanceCycles(spawn_edge - cyc_e);
      checkOutput("zero_seed_spawn", {18'b0, game_over_zero, ypos_zero, letter_zero}, {18'b0, 1'b0, 5'd0, want});
      if (want != 8'h00) checkOutput("zero_seed_nonzero", {31'b0, letter_zero != 8'h00}, 32'd1);
      user_input_zero = want;
      advanceCycles(2);
      checkOutput("zero_seed_hit", {31'b0, correct_zero}, 32'd1);
      advanceCycles(1);
      checkOutput("zero_seed_pulse_width", {31'b0, correct_zero}, 32'd0);
      prev_in = want;
      spawn_edge += 4;
    end

    advanceCycles(2);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/falling_column.md
Name: falling_column

Overview:
- One playfield column of the Flippin Bits game.
- Spawns a pseudo-random 8-bit target byte at the top row and drops it one row per fall period.
- Compares the player's switch byte against the target. Reports a correct hit to the scoring state machine, or game over when the byte reaches the bottom.
- Outputs `letter`/`ypos` feed the display framebuffer builder. `correct`/`game_over` feed the game state machine; three instances run in parallel.

Parameters:
- TICKS_PER_ROW, 12500000, clock cycles per one-row fall (0.25 s at 50 MHz); legal range >= 2.
- ROWS, 30, number of rows; bottom row index is ROWS-1; legal range 2..32.
- SEED, 8'hA5, LFSR load value at reset; 8'h00 is replaced by 8'h01.

Ports:
- clock  in  1  system clock (50 MHz).
- reset_signal  in  1  asynchronous, active-low reset.
- user_input  in  8  player switch byte; asynchronous to the game, no handshake.
- ypos  out  5  current row of the target, 0 = top.
- letter  out  8  current target byte.
- correct  out  1  one-cycle pulse on a successful match.
- game_over  out  1  level; high once the target times out on the bottom row.

Behaviour:
- Async reset (reset_signal=0):
  - state=SPAWN, ypos=0, letter=8'h00, correct=0, game_over=0.
  - tick counter=0, lfsr=SEED (or 8'h01 if SEED==0), in_q=8'h00, match_q=0.
- Input register:
  - in_q <= user_input every cycle.
  - Match is evaluated on in_q (1-cycle input latency).
- LFSR:
  - 8-bit Fibonacci, fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0],fb}.
  - Advances every cycle in every state; period 255; never 0.
- match = (in_q == letter). match_q is match registered, updated only in FALL and cleared in SPAWN.
- A hit is a rising edge of match in FALL: match & ~match_q. Holding switches on the answer scores only once.
- SPAWN (1 cycle):
  - letter <= lfsr; if lfsr == in_q, letter <= lfsr ^ 8'h01 instead (never spawns an already-solved byte).
  - ypos <= 0, tick <= 0, match_q <= 0. Next state FALL.
- FALL:
  - tick increments each cycle.
  - When tick == TICKS_PER_ROW-1: tick <= 0. If ypos == ROWS-1, go to OVER; else ypos <= ypos+1.
  - If a hit occurs, go to HIT.
  - Hit has priority over the row step and over the bottom-row timeout in the same cycle: ypos is not advanced and game_over is not set.
- HIT (1 cycle):
  - correct = 1 (registered, asserted exactly while in HIT); ypos and letter held. Next state SPAWN.
  - Hit-to-new-letter latency is 2 cycles.
- OVER:
  - game_over = 1, held indefinitely; ypos = ROWS-1 and letter held; correct = 0; user_input ignored.
  - Exits only via reset.
- Reset mid-FALL or mid-HIT forces all outputs to reset values immediately (async). First SPAWN occurs on the first clock edge after deassertion.
- Widths:
  - tick width is clog2(TICKS_PER_ROW), wraps only via compare.
  - ypos is 5 bits; unused upper values are never produced.

Test Plan (TICKS_PER_ROW=4, ROWS=4, SEED=8'hA5, user_input=0 unless stated):
1. Reset release -> SPAWN loads letter=8'hA5 on the next cycle; ypos steps 0,1,2,3 every 4 cycles. Four cycles after reaching row 3, game_over=1 and stays high for 50 further cycles; correct never pulses.
2. Set user_input=letter at ypos=1 -> 2 cycles later correct=1 for exactly 1 cycle. Next cycle ypos=0 and letter = next LFSR-derived byte (check against a model).
3. Hold user_input at an old correct value across the respawn -> no second correct pulse; new letter != held input (force a model collision via seed to check the ^8'h01 substitution).
4. Place the match edge on the same cycle as the bottom-row timeout -> correct pulses, game_over stays 0, a new letter spawns.
5. Assert reset_signal=0 mid-FALL at ypos=2, tick=1 -> outputs zero asynchronously, before the next clock edge. After release, letter=8'hA5 again.
6. SEED=8'h00 -> first letter=8'h01. Run 255 spawns: no letter is ever 8'h00 (unless forced by the collision substitution); LFSR sequence repeats at 255.
